sized_dmem_ctrl: RTL
====================

// Module: sized_dmem_ctrl
// PURPOSE
//  Parametrised data-memory block with sized access: byte, half and word loads/stores.
//  Loads support sign- or zero-extension. Access latency is configurable as wait states.
//  Sits between the mips core's load/store path and the word-organised data RAM,
//  in place of the single-cycle byte/word dmem.
//  Uses a req/ready handshake so the core can stall on slow memory.
// PARAMETERS
//  DEPTH_WORDS  64  RAM depth in 32-bit words; power of two, >=4
//  WAIT_CYCLES  1   extra cycles between request acceptance and ready; 0..15
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   synchronous, active-high reset
//  req          in   1   access request; sampled only in IDLE
//  we           in   1   1=store, 0=load; sampled with req
//  size         in   2   00=byte, 01=half, 10=word, 11=word
//  unsigned_ld  in   1   1=zero-extend loads, 0=sign-extend; ignored for word
//  addr         in   32  byte address
//  wdata        in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  rdata        out  32  extended load result; valid when ready=1, held until next ready
//  ready        out  1   one-cycle pulse: access complete
//  busy         out  1   high from the cycle after acceptance through the ready cycle
//  misalign     out  1   one-cycle pulse with ready on a misaligned access; 0 without the macro
// BEHAVIOUR
//  Reset:
//  - FSM=IDLE; ready=0, busy=0, misalign=0, rdata=0, wait counter=0.
//  - RAM contents are not reset.
//  FSM:
//  - IDLE: if req=1, latch we/size/unsigned_ld/addr/wdata, load cnt=WAIT_CYCLES, go to WAIT.
//  - WAIT: if cnt==0, go to DONE; else cnt decrements.
//  - DONE: commit the access, pulse ready=1, return to IDLE.
//  - Latency: with req accepted at edge N, ready is high in the cycle after edge N+WAIT_CYCLES+1.
//  - Back-to-back: req may be high in the ready cycle, but it is accepted only on the next IDLE
//    cycle. Minimum spacing is WAIT_CYCLES+3 cycles.
//  - req while busy=1 is ignored; no queueing, no error.
//  Addressing:
//  - Word index = addr[$clog2(DEPTH_WORDS)+1:2]; upper bits are ignored, so the address
//    wraps modulo DEPTH_WORDS*4.
//  - Little-endian lanes. Byte lane = addr[1:0]. Half lane = addr[1] (0 -> [15:0], 1 -> [31:16]).
//  Stores:
//  - Written on the DONE edge with per-lane byte enables; unselected bytes are unchanged.
//  - Byte uses wdata[7:0]; half uses wdata[15:0].
//  Loads:
//  - The selected lane is extracted from the RAM word read in DONE, then extended to 32 bits
//    per unsigned_ld.
//  - Stores leave rdata unchanged.
//  Reset mid-operation: the pending access is abandoned, no write is committed, and no ready
//  pulse is produced.
//  Aligned by definition: byte at any address, half with addr[0]=0, word with addr[1:0]=00.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//  - Misaligned half/word requests still complete with ready.
//  - misalign=1 in the ready cycle.
//  - Store: no bytes are written. Load: rdata=32'h0.
//  MISALIGN_TRAP_EN undefined:
//  - misalign is tied 0.
//  - Offending low address bits are forced to zero: half ignores addr[0], word ignores addr[1:0].
//  - The access proceeds as aligned.
// TESTING
//  1. Reset held 2 cycles with req=1 -> ready=0, busy=0, rdata=0; no access after reset falls.
//  2. Store word 32'hA1B2C3D4 to addr 0x10, then load word from 0x10 -> rdata=32'hA1B2C3D4;
//     ready exactly WAIT_CYCLES+1 cycles after the acceptance edge.
//  3. Store byte 8'h80 to 0x13 over word 0 at 0x10. Then:
//     - load byte signed from 0x13 -> 32'hFFFFFF80
//     - load byte unsigned from 0x13 -> 32'h00000080
//     - load word from 0x10 -> 32'h80000000
//  4. Store half 16'h8001 to 0x22. Then:
//     - load half signed -> 32'hFFFF8001
//     - load half unsigned -> 32'h00008001
//     - bytes at 0x20..0x21 unchanged
//  5. Misaligned store word 0xDEADBEEF to 0x31, existing word 0 at 0x30:
//     - with MISALIGN_TRAP_EN: misalign=1 with ready; word at 0x30 stays 0
//     - without MISALIGN_TRAP_EN: misalign=0; word at 0x30 = 0xDEADBEEF
//  6. Store started, reset asserted in WAIT -> target word unchanged, no ready pulse.
//     Also: req pulsed while busy -> ignored.
//     Also: addr = DEPTH_WORDS*4+4 aliases to word index 1.

Source files
------------

// File: rtl/sized_dmem_ctrl.sv
// Sized (byte/half/word) data-memory controller with req/ready handshake and programmable wait states.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module sized_dmem_ctrl #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        misalign
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t         r_state;
   logic [3:0]     r_cnt;
   logic           r_we;
   logic [1:0]     r_size;
   logic           r_uns;
   logic [AW+1:0]  r_addr;
   logic [31:0]    r_wdata;
   logic [31:0]    r_rdata;
   logic           r_ready;
   logic           r_busy;
   logic [31:0]    r_mem [DEPTH_WORDS];

   logic [AW-1:0]  w_idx;
   logic [1:0]     w_lane;
   logic [3:0]     w_be;
   logic [31:0]    w_wword;
   logic [31:0]    w_rword;
   logic [31:0]    w_ld;
   logic [31-AW-2:0] w_unused_addr;

   assign w_unused_addr = addr[31:AW+2];

   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] sz,
                                            input logic [1:0] lane, input logic uns);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (sz)
         2'b00:   load_ext = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   load_ext = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: load_ext = sh;
      endcase
   endfunction

   assign w_idx   = r_addr[AW+1:2];
   assign w_rword = r_mem[w_idx];

`ifdef MISALIGN_TRAP_EN
   logic w_mis;
   logic r_mis;
   assign w_mis = (r_size[1] && (r_addr[1:0] != 2'b00)) ||
                  ((r_size == 2'b01) && r_addr[0]);
   assign misalign = r_mis;
`else
   assign misalign = 1'b0;
`endif

   // Misaligned low bits are dropped so the lane always lands on a natural boundary.
   always_comb begin
      w_lane  = r_addr[1:0];
      w_be    = 4'b0001 << r_addr[1:0];
      w_wword = {4{r_wdata[7:0]}};
      if (r_size[1]) begin
         w_lane  = 2'b00;
         w_be    = 4'b1111;
         w_wword = r_wdata;
      end else if (r_size[0]) begin
         w_lane  = {r_addr[1], 1'b0};
         w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
         w_wword = {2{r_wdata[15:0]}};
      end
      w_ld = load_ext(w_rword, r_size, w_lane, r_uns);
`ifdef MISALIGN_TRAP_EN
      if (w_mis) begin
         w_be = 4'b0000;
         w_ld = 32'h0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_rdata <= 32'h0;
`ifdef MISALIGN_TRAP_EN
         r_mis   <= 1'b0;
`endif
      end else begin
         r_ready <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         r_mis   <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_we    <= we;
                  r_size  <= size;
                  r_uns   <= unsigned_ld;
                  r_addr  <= addr[AW+1:0];
                  r_wdata <= wdata;
                  r_cnt   <= 4'(WAIT_CYCLES);
                  r_busy  <= 1'b1;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               // Ready and load data are registered on entry to DONE so they appear together.
               if (r_cnt == 4'd0) begin
                  r_state <= S_DONE;
                  r_ready <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                  r_mis   <= w_mis;
`endif
                  if (!r_we) r_rdata <= w_ld;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Store commits on the edge leaving DONE; reset on that edge abandons it.
   always_ff @(posedge clk) begin
      if (!reset && (r_state == S_DONE) && r_we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
         end
      end
   end

   assign rdata = r_rdata;
   assign ready = r_ready;
   assign busy  = r_busy;

endmodule
